// File: rtl/one_hot_pkg.sv
// Shared constants and a reusable binary-to-one-hot helper for lane decoders.
package one_hot_pkg;

  localparam int BIN_W_DEF     = 4;
  localparam int ONE_HOT_W_DEF = 16;

  // Default-width helper; indices past the vector width return all zeros.
  function automatic logic [ONE_HOT_W_DEF-1:0] bin_to_one_hot(input logic [BIN_W_DEF-1:0] bin);
    logic [ONE_HOT_W_DEF-1:0] vec;
    vec = '0;
    for (int k = 0; k < ONE_HOT_W_DEF; k++) begin
      vec[k] = (bin == BIN_W_DEF'(k));
    end
    return vec;
  endfunction

endpackage

// File: rtl/one_hot_if.sv
// Index-in / one-hot-out bundle between a requester and the one_hot encoder.
interface one_hot_if
  import one_hot_pkg::*;
#(
  parameter int BIN_W     = BIN_W_DEF,
  parameter int ONE_HOT_W = ONE_HOT_W_DEF
);

  logic [BIN_W-1:0]     bin_i;
  logic                 valid_i;
  logic [ONE_HOT_W-1:0] one_hot_o;
  logic                 valid_o;
  logic                 err_o;

  modport master (
    output bin_i,
    output valid_i,
    input  one_hot_o,
    input  valid_o,
    input  err_o
  );

  modport slave (
    input  bin_i,
    input  valid_i,
    output one_hot_o,
    output valid_o,
    output err_o
  );

endinterface

// File: rtl/one_hot_dec.sv
// Combinational binary-to-one-hot decode with an out-of-range flag.
module one_hot_dec
  import one_hot_pkg::*;
#(
  parameter int BIN_W     = BIN_W_DEF,
  parameter int ONE_HOT_W = ONE_HOT_W_DEF
) (
  input  logic [BIN_W-1:0]     i_bin,
  output logic [ONE_HOT_W-1:0] o_vec,
  output logic                 o_oor
);

  // Compare-per-lane rather than a shift so an out-of-range index can
  // never alias onto a low lane: no lane matches, the vector stays zero.
  always_comb begin
    o_vec = '0;
    for (int k = 0; k < ONE_HOT_W; k++) begin
      o_vec[k] = (i_bin == BIN_W'(k));
    end
  end

  always_comb begin
    o_oor = ({1'b0, i_bin} >= (BIN_W + 1)'(ONE_HOT_W));
  end

endmodule

// File: rtl/one_hot.sv
// Registered binary-to-one-hot encoder, 1-cycle latency, one input per cycle.
// No backpressure; the one-hot word holds while idle and out-of-range indices raise err_o.
module one_hot
  import one_hot_pkg::*;
#(
  parameter int BIN_W     = BIN_W_DEF,
  parameter int ONE_HOT_W = ONE_HOT_W_DEF
) (
  input  logic    clk,
  input  logic    rst,
  one_hot_if.slave bus
);

  if (ONE_HOT_W < 1 || ONE_HOT_W > (1 << BIN_W)) begin : g_bad_width
    $error("one_hot: ONE_HOT_W=%0d outside 1..2**BIN_W (BIN_W=%0d)", ONE_HOT_W, BIN_W);
  end

  logic [ONE_HOT_W-1:0] w_vec;
  logic                 w_oor;

  logic [ONE_HOT_W-1:0] r_one_hot;
  logic                 r_valid;
  logic                 r_err;

  one_hot_dec #(
    .BIN_W     (BIN_W),
    .ONE_HOT_W (ONE_HOT_W)
  ) u_dec (
    .i_bin (bus.bin_i),
    .o_vec (w_vec),
    .o_oor (w_oor)
  );

  // Reset wins over a same-cycle valid input, so that input is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_one_hot <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= bus.valid_i;
      r_err   <= bus.valid_i & w_oor;
      if (bus.valid_i) begin
        r_one_hot <= w_vec;
      end
    end
  end

  assign bus.one_hot_o = r_one_hot;
  assign bus.valid_o   = r_valid;
  assign bus.err_o     = r_err;

endmodule

// File: tb/tb_one_hot.sv
// Directed and random checks of one_hot at full (16) and partial (10) decode widths.
module tb_one_hot;

  typedef struct packed {
    logic [15:0] oh16;
    logic        e16;
    logic [9:0]  oh10;
    logic        e10;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  exp_t        sb[$];
  logic [15:0] m16 = '0;
  logic [9:0]  m10 = '0;

  one_hot_if #(.BIN_W(4), .ONE_HOT_W(16)) if16 ();
  one_hot_if #(.BIN_W(4), .ONE_HOT_W(10)) if10 ();

  one_hot #(.BIN_W(4), .ONE_HOT_W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  one_hot #(.BIN_W(4), .ONE_HOT_W(10)) u_dut10 (.clk(clk), .rst(rst), .bus(if10.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the model's prediction, then compare after the edge.
  task automatic step(input string name, input logic r, input logic v, input logic [3:0] b);
    exp_t e;
    rst         = r;
    if16.valid_i = v;
    if16.bin_i   = b;
    if10.valid_i = v;
    if10.bin_i   = b;
    e = '0;
    if (r) begin
      m16 = '0;
      m10 = '0;
    end else if (v) begin
      e.v = 1'b1;
      m16 = 16'(1) << b;
      if (int'(b) < 10) begin
        m10 = 10'(1) << b;
      end else begin
        m10   = '0;
        e.e10 = 1'b1;
      end
    end
    e.oh16 = m16;
    e.oh10 = m10;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({name, ".oh16"},  32'(if16.one_hot_o), 32'(e.oh16));
    check({name, ".v16"},   32'(if16.valid_o),   32'(e.v));
    check({name, ".e16"},   32'(if16.err_o),     32'(e.e16));
    check({name, ".oh10"},  32'(if10.one_hot_o), 32'(e.oh10));
    check({name, ".v10"},   32'(if10.valid_o),   32'(e.v));
    check({name, ".e10"},   32'(if10.err_o),     32'(e.e10));
    check({name, ".pop16"}, 32'($countones(if16.one_hot_o) <= 1), 32'd1);
    check({name, ".pop10"}, 32'($countones(if10.one_hot_o) <= 1), 32'd1);
  endtask

  initial begin
    if16.valid_i = 1'b0;
    if16.bin_i   = '0;
    if10.valid_i = 1'b0;
    if10.bin_i   = '0;
    #2;

    // Reset held with a valid input present, then released idle.
    step("rst0", 1'b1, 1'b1, 4'd5);
    step("rst1", 1'b1, 1'b1, 4'd5);
    step("rel",  1'b0, 1'b0, 4'd5);

    // Back-to-back sweep of every index.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("sweep%0d", i), 1'b0, 1'b1, 4'(i));
    end

    // Output holds while idle even if the index changes.
    step("hold_a", 1'b0, 1'b1, 4'd7);
    step("hold_b", 1'b0, 1'b0, 4'd3);
    step("hold_c", 1'b0, 1'b0, 4'd3);

    // Range boundary on the 10-lane instance.
    step("oor9",  1'b0, 1'b1, 4'd9);
    step("oor10", 1'b0, 1'b1, 4'd10);
    step("oor15", 1'b0, 1'b1, 4'd15);
    step("oor0",  1'b0, 1'b1, 4'd0);

    // An input accepted alongside reset must leave no trace.
    step("mid_pre", 1'b0, 1'b1, 4'd2);
    step("mid_rst", 1'b1, 1'b1, 4'd12);
    step("mid_a",   1'b0, 1'b0, 4'd12);
    step("mid_b",   1'b0, 1'b0, 4'd0);

    for (int i = 0; i < 1000; i++) begin
      step($sformatf("rnd%0d", i),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/one_hot.md
Name: one_hot

Overview:
Registered binary-to-one-hot encoder. Converts a BIN_W-bit binary index into a ONE_HOT_W-bit one-hot word, with one clock cycle of latency. Used as a decode stage ahead of per-lane enables and selects, for example for the 16 lanes at the default width. Indices outside the one-hot range are flagged rather than silently aliased.

Parameters:
BIN_W, 4, width of the binary index input.
ONE_HOT_W, 16, width of the one-hot output. Legal range is 1 to 2**BIN_W; default is the full 2**BIN_W decode.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
bin_i  input  BIN_W  binary index to encode.
valid_i  input  1  qualifies bin_i; sampled on every rising edge.
one_hot_o  output  ONE_HOT_W  registered one-hot result; bit[k] set when the captured index is k.
valid_o  output  1  registered; high for one cycle per accepted input.
err_o  output  1  registered; high when the captured index is >= ONE_HOT_W.

Behaviour:
- Reset: on a rising edge with rst=1, one_hot_o=0, valid_o=0, err_o=0. Reset takes priority over valid_i.
- Latency: exactly 1 cycle. If valid_i=1 at edge N, the results appear after edge N and stay stable until the next accepted input.
- No stall or backpressure. One input is accepted per cycle, so back-to-back valid_i gives back-to-back results.
- Encode rule for an accepted input:
  - If bin_i < ONE_HOT_W: one_hot_o = 1 << bin_i (exactly one bit set) and err_o=0.
  - If bin_i >= ONE_HOT_W: one_hot_o = 0 and err_o=1. Out-of-range indices never wrap or alias onto a lower lane.
- Idle (valid_i=0, rst=0): valid_o=0, err_o=0, and one_hot_o holds its previous value.
- Output invariant: popcount(one_hot_o) is 0 or 1 at all times. It is 0 only after reset or after an error.
- Reset mid-stream: an input accepted in the same cycle rst is asserted is discarded. No result for it appears after reset is released.
- Boundaries:
  - bin_i=0 gives bit 0.
  - bin_i=ONE_HOT_W-1 gives the MSB.
  - With the default parameters every index is in range, so err_o never asserts.
- Encoding is width-generic: a loop or shift over ONE_HOT_W. No hard-coded case table.
- Elaboration check: fail elaboration if ONE_HOT_W > 2**BIN_W or ONE_HOT_W < 1.

Decomposition:
- Shared package: default constants BIN_W_DEF=4 and ONE_HOT_W_DEF=16, plus a one-hot function of type bin -> vector for reuse by other decoders.
- Sub-module one_hot_dec: purely combinational encoder producing the vector and an out-of-range flag.
- The top level instantiates one_hot_dec and adds the registers for one_hot_o, valid_o and err_o, plus reset handling.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with valid_i=1 and bin_i=5 -> one_hot_o=16'h0000, valid_o=0, err_o=0 throughout and on the first cycle after release.
2. Exhaustive sweep with the defaults: bin_i=0..15 back-to-back with valid_i=1 -> one cycle later one_hot_o = 16'h0001, 16'h0002, ..., 16'h8000 in order, valid_o=1 every cycle, err_o=0.
3. Hold on idle: send bin_i=7, then drop valid_i and change bin_i to 3 -> one_hot_o stays 16'h0080 and valid_o=0.
4. Out-of-range with BIN_W=4, ONE_HOT_W=10: bin_i=9 -> 10'b10_0000_0000, err_o=0; bin_i=10 and bin_i=15 -> one_hot_o=0, err_o=1, valid_o=1.
5. Reset mid-stream: valid_i=1, bin_i=12 in the same cycle rst=1 -> the following cycle shows one_hot_o=0 and valid_o=0, with no 16'h1000 ever appearing.
6. Randomised: 1000 random (valid_i, bin_i, occasional rst) cycles checked against a reference model of 1<<bin_i and the range check -> invariant popcount(one_hot_o) <= 1 holds on every cycle.
